// File: rtl/kb_pkg.sv
// Shared types and constants for the keyboard ASCII FIFO controller.
package kb_pkg;

    localparam int unsigned KB_ADDR_W = 8;
    localparam int unsigned KB_DATA_W = 8;
    localparam logic [7:0] KB_EMPTY_CHAR = 8'h00;

    typedef enum logic [1:0] {
        StIdle,
        StRdIssue,
        StRdCap,
        StRdEmpty
    } kb_state_e;

endpackage

// File: rtl/kb_fifo_ctrl_if.sv
// Keyboard, CPU and RAM-port signals of the FIFO controller.
// The controller takes the slave view; the surrounding system uses master.
interface kb_fifo_ctrl_if import kb_pkg::*; #(
    parameter int unsigned ADDR_W = KB_ADDR_W,
    parameter int unsigned DATA_W = KB_DATA_W
);

    logic              kb_ready;
    logic [DATA_W-1:0] kb_data;
    logic              sel;
    logic              rw;
    logic              cpu_wdata0;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_wena;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;

    modport slave (
        input  kb_ready, kb_data, sel, rw, cpu_wdata0, ram_rdata,
        output ram_addr, ram_wena, ram_wdata, rdata, rvalid
    );

    modport master (
        output kb_ready, kb_data, sel, rw, cpu_wdata0, ram_rdata,
        input  ram_addr, ram_wena, ram_wdata, rdata, rvalid
    );

endinterface

// File: rtl/kb_edge_det.sv
// Registered rising-edge detector: one pulse per assertion of d_i.
module kb_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic rise_o
);

    logic d_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d_i;
        end
    end

    assign rise_o = d_i & ~d_q;

endmodule

// File: rtl/kb_fifo_ctrl.sv
// Circular-FIFO controller for the single-port keyboard ASCII RAM.
// Define KB_FIFO_OVERWRITE_EN to overwrite the oldest entry when full instead of dropping.
module kb_fifo_ctrl import kb_pkg::*; #(
    parameter int unsigned ADDR_W = KB_ADDR_W,
    parameter int unsigned DATA_W = KB_DATA_W
) (
    input  logic            clk,
    input  logic            rst,
    kb_fifo_ctrl_if.slave   bus,
    output logic [ADDR_W:0] count_o,
    output logic            empty_o,
    output logic            full_o,
    output logic            overflow_o
);

    localparam logic [ADDR_W:0] DepthCnt = (ADDR_W + 1)'(2 ** ADDR_W);

    kb_state_e         state_q;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              hold_v_q, hold_v_d;
    logic [DATA_W-1:0] hold_d_q, hold_d_d;
    logic              overflow_q, overflow_d;
    logic [ADDR_W-1:0] ram_addr_q;
    logic              ram_wena_q;
    logic [DATA_W-1:0] ram_wdata_q, rdata_q;
    logic              rvalid_q;

    logic rd_edge, full, wr_slot, wr_go, ovw_go, drop_full, pop, hold_used, kb_drop;

    kb_edge_det u_rd_edge (
        .clk    (clk),
        .rst    (rst),
        .d_i    (bus.sel & ~bus.rw),
        .rise_o (rd_edge)
    );

    always_comb begin
        full      = (count_q == DepthCnt);
        // Port is free in IDLE without a competing read, and in RD_CAP.
        wr_slot   = ((state_q == StIdle) && !rd_edge) || (state_q == StRdCap);
        wr_go     = wr_slot && hold_v_q && !full;
        ovw_go    = 1'b0;
        drop_full = 1'b0;
`ifdef KB_FIFO_OVERWRITE_EN
        ovw_go    = (state_q == StIdle) && !rd_edge && hold_v_q && full;
`else
        drop_full = wr_slot && hold_v_q && full;
`endif
        pop       = (state_q == StRdIssue);
        hold_used = wr_go || ovw_go || drop_full;

        wr_ptr_d = (wr_go || ovw_go) ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = (pop || ovw_go) ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q + {{ADDR_W{1'b0}}, wr_go} - {{ADDR_W{1'b0}}, pop};

        hold_v_d = hold_v_q && !hold_used;
        hold_d_d = hold_d_q;
        kb_drop  = 1'b0;
        if (bus.kb_ready) begin
            if (!hold_v_q || hold_used) begin
                hold_v_d = 1'b1;
                hold_d_d = bus.kb_data;
            end else begin
                kb_drop = 1'b1;
            end
        end

        overflow_d = overflow_q;
        if (bus.sel && bus.rw && bus.cpu_wdata0) overflow_d = 1'b0;
        if (kb_drop || drop_full || ovw_go) overflow_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            hold_v_q    <= 1'b0;
            hold_d_q    <= '0;
            overflow_q  <= 1'b0;
            ram_addr_q  <= '0;
            ram_wena_q  <= 1'b0;
            ram_wdata_q <= '0;
            rdata_q     <= '0;
            rvalid_q    <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            hold_v_q   <= hold_v_d;
            hold_d_q   <= hold_d_d;
            overflow_q <= overflow_d;
            ram_wena_q <= 1'b0;
            rvalid_q   <= 1'b0;
            if (wr_go || ovw_go) begin
                ram_addr_q  <= wr_ptr_q;
                ram_wena_q  <= 1'b1;
                ram_wdata_q <= hold_d_q;
            end
            unique case (state_q)
                StIdle: begin
                    if (rd_edge) begin
                        if (count_q == '0) begin
                            state_q <= StRdEmpty;
                        end else begin
                            state_q    <= StRdIssue;
                            ram_addr_q <= rd_ptr_q;
                        end
                    end
                end
                StRdIssue: state_q <= StRdCap;
                StRdCap: begin
                    rdata_q  <= bus.ram_rdata;
                    rvalid_q <= 1'b1;
                    state_q  <= StIdle;
                end
                StRdEmpty: begin
                    rdata_q  <= DATA_W'(KB_EMPTY_CHAR);
                    rvalid_q <= 1'b1;
                    state_q  <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_wena  = ram_wena_q;
    assign bus.ram_wdata = ram_wdata_q;
    assign bus.rdata     = rdata_q;
    assign bus.rvalid    = rvalid_q;
    assign count_o       = count_q;
    assign empty_o       = (count_q == '0);
    assign full_o        = full;
    assign overflow_o    = overflow_q;

endmodule

// File: tb/tb_kb_fifo_ctrl.sv
// Directed bench for kb_fifo_ctrl with a RAM model and a read-data scoreboard.
module tb_kb_fifo_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [8:0] count;
    logic       empty, full, overflow;

    kb_fifo_ctrl_if #(.ADDR_W(8), .DATA_W(8)) bus ();

    kb_fifo_ctrl #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .count_o    (count),
        .empty_o    (empty),
        .full_o     (full),
        .overflow_o (overflow)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [256];
    always @(posedge clk) begin
        if (bus.ram_wena) mem[bus.ram_addr] <= bus.ram_wdata;
        bus.ram_rdata <= mem[bus.ram_addr];
    end

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int rv_cnt = 0;
    int last_rv_cyc = 0;
    int t_edge = 0;
    logic [7:0] last_wr_addr = 8'hFF;
    logic [7:0] mdl[$];
    logic [7:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.ram_wena) last_wr_addr = bus.ram_addr;
        if (bus.rvalid) begin
            rv_cnt++;
            last_rv_cyc = cyc;
            check("rvalid_pending", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) check("rdata", 32'(bus.rdata), 32'(exp_q.pop_front()));
        end
    end

    task automatic key(input logic [7:0] d);
        @(posedge clk); #1;
        bus.kb_ready = 1'b1;
        bus.kb_data  = d;
        @(posedge clk); #1;
        bus.kb_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        if (mdl.size() < 256) begin
            mdl.push_back(d);
        end else begin
`ifdef KB_FIFO_OVERWRITE_EN
            void'(mdl.pop_front());
            mdl.push_back(d);
`endif
        end
    endtask

    task automatic rd(input int hold, input string tag);
        logic nonempty;
        int   rv0;
        nonempty = (mdl.size() > 0);
        if (nonempty) exp_q.push_back(mdl.pop_front());
        else exp_q.push_back(8'h00);
        rv0 = rv_cnt;
        @(posedge clk); #1;
        bus.sel = 1'b1;
        bus.rw  = 1'b0;
        t_edge  = cyc;
        repeat (hold) @(posedge clk);
        #1 bus.sel = 1'b0;
        for (int i = 0; i < 20 && rv_cnt == rv0; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_rvalid_cnt"}, 32'(rv_cnt - rv0), 32'd1);
        if (nonempty) check({tag, "_latency"}, 32'(last_rv_cyc - t_edge), 32'd3);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rdata"}, 32'(bus.rdata), 32'd0);
        check({tag, "_rvalid"}, 32'(bus.rvalid), 32'd0);
        check({tag, "_overflow"}, 32'(overflow), 32'd0);
        check({tag, "_wena"}, 32'(bus.ram_wena), 32'd0);
        check({tag, "_addr"}, 32'(bus.ram_addr), 32'd0);
        check({tag, "_wdata"}, 32'(bus.ram_wdata), 32'd0);
        check({tag, "_count"}, 32'(count), 32'd0);
        check({tag, "_empty"}, 32'(empty), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int rv0;
        rst = 1'b1;
        bus.kb_ready = 1'b0; bus.kb_data = 8'h00;
        bus.sel = 1'b0; bus.rw = 1'b0; bus.cpu_wdata0 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        check("reset_full", 32'(full), 32'd0);
        rst = 1'b0;

        // Single key then pop
        key(8'h41);
        check("t1_count", 32'(count), 32'd1);
        check("t1_wr_addr", 32'(last_wr_addr), 32'd0);
        rd(1, "t1_rd");
        check("t1_count_after", 32'(count), 32'd0);
        check("t1_empty", 32'(empty), 32'd1);

        // Pop from empty
        rd(1, "t2_rd");
        check("t2_count", 32'(count), 32'd0);
        key(8'h5A);
        check("t2_wr_addr", 32'(last_wr_addr), 32'd1);
        rd(1, "t2_rd_next");

        // Long select gives a single pop
        key(8'h31); key(8'h32); key(8'h33);
        check("t3_count", 32'(count), 32'd3);
        rd(10, "t3_rd_long");
        check("t3_count_after", 32'(count), 32'd2);
        rd(1, "t3_drain0");
        rd(1, "t3_drain1");

        // Key arrives in the same cycle as a read edge
        key(8'h45);
        exp_q.push_back(mdl.pop_front());
        mdl.push_back(8'h62);
        rv0 = rv_cnt;
        @(posedge clk); #1;
        bus.kb_ready = 1'b1; bus.kb_data = 8'h62;
        bus.sel = 1'b1; bus.rw = 1'b0;
        @(posedge clk); #1;
        bus.kb_ready = 1'b0; bus.sel = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("t4_rvalid_cnt", 32'(rv_cnt - rv0), 32'd1);
        check("t4_count", 32'(count), 32'd1);
        check("t4_overflow", 32'(overflow), 32'd0);
        rd(1, "t4_rd_new");

        // Fill to DEPTH, then one more key
        for (int i = 0; i < 256; i++) key(8'(i * 7 + 3));
        check("t5_full_before", 32'(full), 32'd1);
        check("t5_ovf_before", 32'(overflow), 32'd0);
        key(8'h7A);
        check("t5_full", 32'(full), 32'd1);
        check("t5_overflow", 32'(overflow), 32'd1);
        check("t5_count", 32'(count), 32'd256);
        for (int i = 0; i < 256; i++) rd(1, "t5_rd");
        check("t5_empty", 32'(empty), 32'd1);

        // Overflow clear by CPU write
        @(posedge clk); #1;
        bus.sel = 1'b1; bus.rw = 1'b1; bus.cpu_wdata0 = 1'b1;
        @(posedge clk); #1;
        bus.sel = 1'b0; bus.rw = 1'b0; bus.cpu_wdata0 = 1'b0;
        check("t6_ovf_clear", 32'(overflow), 32'd0);
        check("t6_count", 32'(count), 32'd0);

        // Interleaved traffic across pointer wrap
        for (int i = 0; i < 300; i++) begin
            key(8'(i) ^ 8'hA5);
            rd(1, "t7_rd");
        end
        check("t7_count", 32'(count), 32'd0);

        // Reset while the read is in flight
        key(8'h55);
        rv0 = rv_cnt;
        @(posedge clk); #1;
        bus.sel = 1'b1; bus.rw = 1'b0;
        @(posedge clk); #1;
        bus.sel = 1'b0;
        check("t8_addr_issue", 32'(bus.ram_addr), 32'(last_wr_addr));
        #2 rst = 1'b1;
        mdl.delete();
        exp_q.delete();
        @(posedge clk); #1;
        check_reset_outputs("t8_rst");
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("t8_no_rvalid", 32'(rv_cnt - rv0), 32'd0);
        check("t8_count", 32'(count), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/kb_fifo_ctrl.md
Name: kb_fifo_ctrl

Overview:
- Controller/arbiter for the keyboard ASCII RAM (single-port, synchronous read, 1-cycle latency).
- Turns that RAM into a circular FIFO.
- Shares its one port between keyboard writes (`kb_ready` pulses) and CPU bus reads (pops).
- Sits between keyboard→kb2ascii and the RAM; replaces the ad-hoc ready/address mux scheme.

Parameters:
- ADDR_W, 8, FIFO/RAM address width; DEPTH = 2**ADDR_W.
- DATA_W, 8, entry width (ASCII).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- kb_ready  in  1  one-cycle pulse, `kb_data` valid.
- kb_data  in  DATA_W  ASCII code from kb2ascii.
- sel  in  1  CPU bus select for this device.
- rw  in  1  CPU direction, 0=read, 1=write.
- cpu_wdata0  in  1  bit 0 of CPU write data; 1 clears overflow flag.
- ram_addr  out  ADDR_W  RAM address.
- ram_wena  out  1  RAM write enable.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM read data, valid the cycle after address issue.
- rdata  out  DATA_W  popped character to CPU.
- rvalid  out  1  one-cycle pulse, `rdata` updated.
- count  out  ADDR_W+1  entries stored, 0..DEPTH.
- empty  out  1  count==0.
- full  out  1  count==DEPTH.
- overflow  out  1  sticky: keystroke dropped.

Behaviour:
- Reset (async):
  - Pointers wr_ptr=rd_ptr=0, count=0, holding register empty, state=IDLE.
  - Outputs: rdata=0, rvalid=0, overflow=0, ram_wena=0, ram_addr=0, ram_wdata=0.
- Read request:
  - rd_req = sel & ~rw, rising-edge detected (registered previous value).
  - One pop per bus access regardless of how long sel is held.
- Write-clear: sel & rw & cpu_wdata0 clears overflow next cycle.
- Keyboard capture: kb_ready loads a 1-entry holding register (hold_v, hold_d). kb input is never stalled.
- FSM:
  - IDLE:
    - Read edge & !empty → RD_ISSUE.
    - Read edge & empty → RD_EMPTY.
    - Else if hold_v → write.
  - RD_ISSUE: ram_addr=rd_ptr, ram_wena=0; rd_ptr+1 (wraps mod DEPTH); count-1 → RD_CAP.
  - RD_CAP: rdata←ram_rdata; rvalid=1 next cycle → IDLE. Port is free here; a pending hold write may issue this cycle.
  - RD_EMPTY: rdata←8'h00, rvalid=1 next cycle, no pointer change → IDLE.
- Write issue (IDLE or RD_CAP, hold_v, !full):
  - ram_addr=wr_ptr, ram_wena=1, ram_wdata=hold_d.
  - wr_ptr+1 mod DEPTH; count+1; hold_v cleared.
- Arbitration: CPU read has priority for the port. A write waits at most 2 cycles (RD_ISSUE only blocks).
- Latency: read edge at cycle T → address at T+1 → rvalid high at T+3.
- Simultaneous events:
  - Write and pop in same cycle (RD_CAP write vs RD_ISSUE pop are distinct cycles): count updates are the sum (net 0 if both).
  - kb_ready while hold_v=1 and the hold entry is issuing this cycle: new byte refills hold.
  - kb_ready while hold_v=1 and not issuing: new byte dropped, overflow=1.
- Full: hold entry with count==DEPTH is discarded, overflow=1, hold_v cleared.
- Reset mid-read: read discarded, no rvalid.
- ram_wena is never high in the same cycle as a read address issue.

Optional Feature:
- Macro: KB_FIFO_OVERWRITE_EN.
- Defined: when full, a pending write overwrites the oldest entry:
  - Write at wr_ptr; wr_ptr+1 and rd_ptr+1; count stays DEPTH; overflow=1.
  - Blocked while a read is in RD_ISSUE/RD_CAP; waits to IDLE.
- Undefined: drop-newest behaviour described above.

Decomposition:
- Shared package kb_pkg:
  - State encoding: IDLE, RD_ISSUE, RD_CAP, RD_EMPTY.
  - KB_ADDR_W=8, KB_DATA_W=8, KB_EMPTY_CHAR=8'h00.
- One natural sub-module: kb_edge_det (registered rising-edge detector for rd_req). The rest stays flat.

Test Plan:
- Reset then single kb_ready with 8'h41; one read edge → RAM write at addr 0; rdata=8'h41 with rvalid 3 cycles after edge; count 1→0, empty=1.
- Read on empty FIFO → rdata=8'h00, rvalid pulses once, rd_ptr stays 0, count stays 0.
- sel&~rw held 10 cycles with 3 entries stored → exactly one pop, count 3→2.
- kb_ready (8'h62) in the same cycle as a read edge with count=1 → read returns the old entry; 8'h62 written in RD_CAP; final count=1; no overflow.
- 256 writes, then a 257th (8'h7A):
  - Macro off: full=1, overflow=1, count=256, first read returns entry 0.
  - Macro on: count=256, next read returns entry 1, last read returns 8'h7A.
- Wrap and clear: write 300 / read 300 interleaved → data order preserved across pointer wrap. Write with cpu_wdata0=1 → overflow=0. Assert rst between RD_ISSUE and RD_CAP → no rvalid, all outputs at reset values.
